// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALUControl values, FSM state encoding and the datapath control bundle.
package mips_pkg;

    localparam int unsigned OPCODE_WIDTH  = 6;
    localparam int unsigned FUNCT_WIDTH   = 6;
    localparam int unsigned CONTROL_WIDTH = 3;
    localparam int unsigned STATE_WIDTH   = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_R    = 6'b000000;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW   = 6'b101011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPCODE_WIDTH-1:0] OP_J    = 6'b000010;

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_WIDTH-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_WIDTH-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_WIDTH-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_WIDTH-1:0] FN_MUL = 6'b011000;

    // Must stay in lockstep with the ALU's operation decode.
    localparam logic [CONTROL_WIDTH-1:0] ALU_AND = 3'b000;
    localparam logic [CONTROL_WIDTH-1:0] ALU_OR  = 3'b001;
    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = 3'b010;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SUB = 3'b100;
    localparam logic [CONTROL_WIDTH-1:0] ALU_MUL = 3'b101;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLT = 3'b110;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    function automatic logic is_known_opcode(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller-to-datapath bundle: instruction fields and flags in, enables and
// mux selects out. master = controller, slave = datapath/ALU side.
interface multicycle_control_unit_if;

    logic [mips_pkg::OPCODE_WIDTH-1:0]  Opcode;
    logic [mips_pkg::FUNCT_WIDTH-1:0]   Funct;
    logic                               ZERO;
    logic                               MemReady;
    logic                               IorD;
    logic                               MemWrite;
    logic                               IRWrite;
    logic                               RegDst;
    logic                               MemtoReg;
    logic                               RegWrite;
    logic                               ALUSrcA;
    logic [1:0]                         ALUSrcB;
    logic [mips_pkg::CONTROL_WIDTH-1:0] ALUControl;
    logic [1:0]                         PCSrc;
    logic                               PCEn;
    logic                               IllegalInstr;

    modport master (
        input  Opcode, Funct, ZERO, MemReady,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, IllegalInstr
    );

    modport slave (
        output Opcode, Funct, ZERO, MemReady,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, IllegalInstr
    );

endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp and the R-type funct field to ALUControl,
// and flags funct codes outside the supported set.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t                   alu_op,
    input  logic [FUNCT_WIDTH-1:0]   funct,
    output logic [CONTROL_WIDTH-1:0] alu_control,
    output logic                     illegal_funct
);

    logic [CONTROL_WIDTH-1:0] funct_control;

    // Funct lookup; unknown codes fall back to add so the instruction still flows.
    always_comb begin
        funct_control = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  funct_control = ALU_ADD;
            FN_SUB:  funct_control = ALU_SUB;
            FN_AND:  funct_control = ALU_AND;
            FN_OR:   funct_control = ALU_OR;
            FN_SLT:  funct_control = ALU_SLT;
            FN_MUL:  funct_control = ALU_MUL;
            default: illegal_funct = 1'b1;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_control;
            default:     alu_control = CONTROL_WIDTH'(0);
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore main controller for the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_control_unit
    import mips_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    multicycle_control_unit_if.master  bus
);

    state_t                   state;
    state_t                   state_next;
    ctrl_t                    ctrl;
    aluop_t                   alu_op;
    logic                     illegal_c;
    logic                     illegal_funct;
    logic [CONTROL_WIDTH-1:0] alu_control;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_FETCH;
        else      state <= state_next;
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (bus.Funct),
        .alu_control   (alu_control),
        .illegal_funct (illegal_funct)
    );

    // Next-state and Moore control decode.
    always_comb begin
        state_next = S_FETCH;
        ctrl       = '0;
        alu_op     = ALUOP_ADD;
        illegal_c  = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = bus.MemReady;
                ctrl.pc_write  = bus.MemReady;
                state_next     = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                illegal_c      = !is_known_opcode(bus.Opcode) ||
                                 ((bus.Opcode == OP_R) && illegal_funct);
                case (bus.Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                if (bus.Opcode == OP_LW)      state_next = S_MEMREAD;
                else if (bus.Opcode == OP_SW) state_next = S_MEMWRITE;
                else                          state_next = S_FETCH;
            end
            S_MEMREAD: begin
                ctrl.iord  = 1'b1;
                state_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_next     = bus.MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                alu_op         = ALUOP_FUNCT;
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.pc_src    = 2'b01;
                ctrl.branch    = 1'b1;
                alu_op         = ALUOP_SUB;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_next     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
            end
            default: begin
                alu_op = ALUOP_NONE;
            end
        endcase
    end

    assign bus.IorD       = ctrl.iord;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.MemtoReg   = ctrl.mem_to_reg;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.PCSrc      = ctrl.pc_src;

    // Architectural strobes are held off for as long as reset is low.
    assign bus.MemWrite     = ctrl.mem_write & RST;
    assign bus.IRWrite      = ctrl.ir_write & RST;
    assign bus.RegWrite     = ctrl.reg_write & RST;
    assign bus.PCEn         = (ctrl.pc_write | (ctrl.branch & bus.ZERO)) & RST;
    assign bus.IllegalInstr = illegal_c & RST;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a per-instruction cycle model
// expands each instruction into expected output vectors checked every cycle.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_unit_if bus();

    multicycle_control_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        mr;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] exp;
        logic        pin_en;
        logic [15:0] pin_val;
    } cyc_t;

    cyc_t        prog[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc_no   = 0;
    logic        chk_en   = 1'b0;
    logic [15:0] exp_vec  = '0;

    localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010,
                           C_SUB = 3'b100, C_MUL = 3'b101, C_SLT = 3'b110;

    // Output vector: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
    // ALUSrcB[1:0] ALUControl[2:0] PCSrc[1:0] PCEn IllegalInstr
    function automatic logic [15:0] got();
        return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                bus.PCSrc, bus.PCEn, bus.IllegalInstr};
    endfunction

    function automatic logic [15:0] mk(input logic iord, mw, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sb, input logic [2:0] ctl,
                                       input logic [1:0] ps, input logic pcen, ill);
        return {iord, mw, irw, rd, m2r, rw, sa, sb, ctl, ps, pcen, ill};
    endfunction

    function automatic void push(input logic r, mr, z, input logic [5:0] op, fn,
                                 input logic [15:0] e);
        cyc_t c;
        c.rst = r; c.mr = mr; c.zero = z; c.op = op; c.fn = fn; c.exp = e;
        c.pin_en = 1'b0; c.pin_val = '0;
        prog.push_back(c);
    endfunction

    function automatic void pin_last(input logic [15:0] v);
        prog[prog.size()-1].pin_en  = 1'b1;
        prog[prog.size()-1].pin_val = v;
    endfunction

    function automatic logic [2:0] r_ctl(input logic [5:0] fn, output logic bad);
        bad = 1'b0;
        case (fn)
            6'b100000: return C_ADD;
            6'b100010: return C_SUB;
            6'b100100: return C_AND;
            6'b100101: return C_OR;
            6'b101010: return C_SLT;
            6'b011000: return C_MUL;
            default: begin bad = 1'b1; return C_ADD; end
        endcase
    endfunction

    // Fetch plus decode: the part every instruction shares.
    function automatic void add_front(input logic [5:0] op, fn, input logic z,
                                      input int fstall);
        logic bad;
        logic ill;
        logic [2:0] unused_ctl;
        for (int i = 0; i < fstall; i++)
            push(1, 0, z, op, fn, mk(0,0,0,0,0,0,0,2'b01,C_ADD,2'b00,0,0));
        push(1, 1, z, op, fn, mk(0,0,1,0,0,0,0,2'b01,C_ADD,2'b00,1,0));
        unused_ctl = r_ctl(fn, bad);
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})
              || (op == 6'b000000 && bad);
        push(1, 1, z, op, fn, mk(0,0,0,0,0,0,0,2'b11,C_ADD,2'b00,0,ill));
    endfunction

    function automatic void add_instr(input logic [5:0] op, fn, input logic z,
                                      input int fstall, mstall);
        logic bad;
        logic [2:0] ctl;
        add_front(op, fn, z, fstall);
        ctl = r_ctl(fn, bad);
        case (op)
            6'b100011: begin
                push(1, 1, z, op, fn, mk(0,0,0,0,0,0,1,2'b10,C_ADD,2'b00,0,0));
                for (int i = 0; i < mstall; i++)
                    push(1, 0, z, op, fn, mk(1,0,0,0,0,0,0,2'b00,C_ADD,2'b00,0,0));
                push(1, 1, z, op, fn, mk(1,0,0,0,0,0,0,2'b00,C_ADD,2'b00,0,0));
                push(1, 1, z, op, fn, mk(0,0,0,0,1,1,0,2'b00,C_ADD,2'b00,0,0));
            end
            6'b101011: begin
                push(1, 1, z, op, fn, mk(0,0,0,0,0,0,1,2'b10,C_ADD,2'b00,0,0));
                for (int i = 0; i < mstall; i++)
                    push(1, 0, z, op, fn, mk(1,1,0,0,0,0,0,2'b00,C_ADD,2'b00,0,0));
                push(1, 1, z, op, fn, mk(1,1,0,0,0,0,0,2'b00,C_ADD,2'b00,0,0));
            end
            6'b000000: begin
                push(1, 1, z, op, fn, mk(0,0,0,0,0,0,1,2'b00,ctl,2'b00,0,0));
                push(1, 1, z, op, fn, mk(0,0,0,1,0,1,0,2'b00,C_ADD,2'b00,0,0));
            end
            6'b000100:
                push(1, 1, z, op, fn, mk(0,0,0,0,0,0,1,2'b00,C_SUB,2'b01,z,0));
            6'b001000: begin
                push(1, 1, z, op, fn, mk(0,0,0,0,0,0,1,2'b10,C_ADD,2'b00,0,0));
                push(1, 1, z, op, fn, mk(0,0,0,0,0,1,0,2'b00,C_ADD,2'b00,0,0));
            end
            6'b000010:
                push(1, 1, z, op, fn, mk(0,0,0,0,0,0,0,2'b00,C_ADD,2'b10,1,0));
            default: ;
        endcase
    endfunction

    // Single compare point: every clocked cycle is checked against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (got() !== exp_vec) begin
                failures++;
                $display("FAIL cycle%0d outputs got=%h expected=%h", cyc_no, got(), exp_vec);
            end
        end
    end

    task automatic step(input cyc_t c);
        @(posedge clk);
        #1;
        rst          = c.rst;
        bus.MemReady = c.mr;
        bus.ZERO     = c.zero;
        bus.Opcode   = c.op;
        bus.Funct    = c.fn;
        exp_vec      = c.exp;
        chk_en       = 1'b1;
        cyc_no++;
        if (c.pin_en) begin
            @(negedge clk);
            #1;
            checks++;
            if (got() !== c.pin_val) begin
                failures++;
                $display("FAIL pin cycle%0d got=%h expected=%h", cyc_no, got(), c.pin_val);
            end
        end
    endtask

    initial begin
        bus.MemReady = 1'b1;
        bus.ZERO     = 1'b0;
        bus.Opcode   = '0;
        bus.Funct    = '0;

        // Reset held three cycles with MemReady high: fetch decode, strobes off.
        for (int i = 0; i < 3; i++)
            push(0, 1, 0, 6'b0, 6'b0, mk(0,0,0,0,0,0,0,2'b01,C_ADD,2'b00,0,0));
        pin_last(16'h00A0);

        add_instr(6'b000000, 6'b100010, 1'b0, 0, 0);           // R sub
        prog[3].pin_en = 1'b1; prog[3].pin_val = 16'h20A2;
        add_instr(6'b100011, 6'b000000, 1'b0, 0, 2);           // LW, 2-cycle stall
        add_instr(6'b101011, 6'b000000, 1'b1, 1, 1);           // SW, fetch+mem stall
        add_front(6'b000100, 6'b000000, 1'b1, 0);              // BEQ taken
        push(1, 1, 1, 6'b000100, 6'b0, mk(0,0,0,0,0,0,1,2'b00,C_SUB,2'b01,1,0));
        pin_last(16'h0246);
        add_instr(6'b000100, 6'b000000, 1'b0, 0, 0);           // BEQ not taken
        add_instr(6'b001000, 6'b000000, 1'b1, 0, 0);           // ADDI
        add_instr(6'b000010, 6'b000000, 1'b0, 0, 0);           // J
        add_instr(6'b111111, 6'b000000, 1'b1, 0, 0);           // illegal opcode
        add_front(6'b000000, 6'b000000, 1'b0, 0);              // illegal funct
        pin_last(16'h01A1);
        push(1, 1, 0, 6'b0, 6'b0, mk(0,0,0,0,0,0,1,2'b00,C_ADD,2'b00,0,0));
        push(1, 1, 0, 6'b0, 6'b0, mk(0,0,0,1,0,1,0,2'b00,C_ADD,2'b00,0,0));
        add_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        add_instr(6'b000000, 6'b100100, 1'b1, 0, 0);
        add_instr(6'b000000, 6'b100101, 1'b0, 0, 0);
        add_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
        add_instr(6'b000000, 6'b011000, 1'b0, 0, 0);

        // SW interrupted by reset while waiting on memory.
        add_front(6'b101011, 6'b000000, 1'b0, 0);
        push(1, 1, 0, 6'b101011, 6'b0, mk(0,0,0,0,0,0,1,2'b10,C_ADD,2'b00,0,0));
        push(1, 0, 0, 6'b101011, 6'b0, mk(1,1,0,0,0,0,0,2'b00,C_ADD,2'b00,0,0));
        push(0, 0, 0, 6'b101011, 6'b0, mk(0,0,0,0,0,0,0,2'b01,C_ADD,2'b00,0,0));
        push(0, 1, 0, 6'b101011, 6'b0, mk(0,0,0,0,0,0,0,2'b01,C_ADD,2'b00,0,0));
        add_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        add_front(6'b000010, 6'b000000, 1'b0, 0);

        while (prog.size() > 0) begin
            step(prog.pop_front());
        end
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main controller for the multicycle MIPS datapath; the driving end of the ALU's ALUControl interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Produces every datapath enable and mux select, plus the 3-bit ALUControl code consumed by the ALU.
- Consumes the ALU's ZERO flag to resolve branches.

Parameters:
OPCODE_WIDTH, 6, instruction opcode field width
FUNCT_WIDTH, 6, R-type funct field width
Control_width, 3, ALUControl width (must match the ALU)

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  asynchronous, active-low reset
Opcode  input  6  IR[31:26]; stable from DECODE until next FETCH
Funct  input  6  IR[5:0]
ZERO  input  1  ALU zero flag (1 = ALUResult==0)
MemReady  input  1  memory access completes this cycle
IorD  output  1  memory address select (0 = PC, 1 = ALUOut)
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  write register select (0 = rt, 1 = rd)
MemtoReg  output  1  writeback select (0 = ALUOut, 1 = Data)
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select (0 = PC, 1 = A reg)
ALUSrcB  output  2  ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2)
ALUControl  output  3  ALU operation code
PCSrc  output  2  PC mux select (00 = ALUResult, 01 = ALUOut, 10 = jump target)
PCEn  output  1  PC load = PCWrite | (Branch & ZERO)
IllegalInstr  output  1  one-cycle pulse in DECODE on an unsupported opcode/funct

Behaviour:
- State register: async clear to FETCH on RST=0. While RST=0, MemWrite, IRWrite, RegWrite, PCEn and IllegalInstr are forced 0. All other outputs follow FETCH decode.
- Default output value in every state: 0. ALUControl default is 010 (add).
- ALUControl encodings: AND 000, OR 001, ADD 010, SUB 100, MUL 101, SLT 110. Codes 011 and 111 are never driven.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- R-type funct map: 100000 -> 010, 100010 -> 100, 100100 -> 000, 100101 -> 001, 101010 -> 110, 011000 -> 101.
- Any other funct: ALUControl = 010, IllegalInstr pulses in DECODE, flow continues normally.
- States, outputs and transitions:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00. IRWrite=PCWrite=MemReady. Stay while MemReady=0, else go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD. Next state: LW/SW -> MEMADR, R -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP. Any other opcode -> FETCH with IllegalInstr=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. LW -> MEMREAD, SW -> MEMWRITE.
  - MEMREAD: IorD=1. Stay until MemReady, then go to MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWRITE: IorD=1, MemWrite=1 held every cycle of the wait. Stay until MemReady, then go to FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from the funct map. Go to ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1. Go to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Go to ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Go to FETCH.
  - Unused state codes: all outputs 0, next state FETCH.
- Latency with MemReady tied high: R = 4, LW = 5, SW = 4, BEQ = 3, ADDI = 4, J = 3 cycles.
- Each memory-wait cycle adds one cycle. Wait length is unbounded; there is no timeout.
- PCEn is combinational from state and ZERO. A ZERO change outside BRANCH has no effect.
- Reset asserted mid-instruction: state is cleared immediately. No further RegWrite or MemWrite occurs. After release, execution restarts at FETCH.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct constants;
  - ALUControl encodings (same values the ALU uses);
  - 4-bit state encodings FETCH = 0 through JUMP = 11.
- One combinational sub-module, alu_decoder: (ALUOp[1:0], Funct) -> ALUControl, IllegalFunct.
  - ALUOp 00 = add, 01 = sub, 10 = funct.
  - Main FSM drives ALUOp.

Test Plan:
- Reset: RST=0 for 3 cycles, MemReady=1 -> IRWrite=0, PCEn=0, RegWrite=0. After release, IRWrite=1 and PCEn=1 in the first cycle (FETCH).
- R-type sub: Opcode=000000, Funct=100010, MemReady=1 -> ALUControl=100 in EXECUTE. RegWrite=1 with RegDst=1 in cycle 4. Back in FETCH in cycle 5.
- LW with memory stall: Opcode=100011, MemReady held 0 for 2 cycles in MEMREAD -> IorD=1 for 3 cycles. MEMWB has RegWrite=1, MemtoReg=1. Total 7 cycles.
- BEQ: Opcode=000100 with ZERO=1 -> PCEn=1, PCSrc=01, ALUControl=100 in cycle 3. Repeat with ZERO=0 -> PCEn=0.
- Illegal opcode 111111 -> IllegalInstr=1 in DECODE, no RegWrite/MemWrite, FETCH in cycle 3. Funct 000000 with R opcode -> IllegalInstr=1, ALUControl=010.
- Mid-op reset: assert RST=0 during MEMWRITE with MemReady=0 -> MemWrite drops the same cycle. Next cycle after release is FETCH.
